// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int STATE_W       = 2;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell used to build ripple-carry adders.
module full_adder (
  input  logic x_i,
  input  logic y_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = x_i ^ y_i ^ cin_i;
  assign cout_o = (x_i & y_i) | (cin_i & (x_i ^ y_i));

endmodule

// File: rtl/ripple_adder.sv
// N-bit ripple-carry adder built from full-adder cells; carry-in is zero.
module ripple_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .x_i   (x[i]),
      .y_i   (y[i]),
      .cin_i (carry[i]),
      .sum_o (sum[i]),
      .cout_o(carry[i+1])
    );
  end

  assign cout = carry[N];

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier: one multiplier bit per RUN cycle, LSB first.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   acc_hi_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [WIDTH:0]     partial;
  logic [WIDTH-1:0]   acc_hi_d;
  logic [WIDTH-1:0]   mplier_d;

  assign addend = mplier_q[0] ? mcand_q : '0;

  ripple_adder #(.N(WIDTH)) u_adder (
    .x   (acc_hi_q),
    .y   (addend),
    .sum (add_sum),
    .cout(add_cout)
  );

  // The multiplier register doubles as the low half of the accumulator:
  // consumed multiplier bits shift out while product bits shift in from the top.
  always_comb begin
    partial  = {add_cout, add_sum};
    acc_hi_d = partial[WIDTH:1];
    mplier_d = {partial[0], mplier_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_hi_q  <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_hi_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_hi_q <= acc_hi_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            product_q <= {acc_hi_d, mplier_d};
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001: Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-004: start  input  1  request to begin a multiply; honoured only in IDLE.
REQ-005: a  input  WIDTH  unsigned multiplicand, sampled on accepting edge only.
REQ-006: b  input  WIDTH  unsigned multiplier, sampled on accepting edge only.
REQ-007: busy  output  1  high while in RUN or DONE; low in IDLE.
REQ-008: done  output  1  single-cycle pulse, high only in DONE.
REQ-009: product  output  2*WIDTH  unsigned a*b of the last completed operation.

Function
REQ-010: The block SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-011: In IDLE with start=1 at an edge, the block SHALL capture a and b into internal registers, clear the accumulator and bit counter, and enter RUN.
REQ-012: In IDLE with start=0, the block SHALL stay in IDLE with all registers unchanged.
REQ-013: Each RUN edge SHALL process one multiplier bit, LSB first: if the current bit is 1, add the multiplicand to the upper WIDTH bits of the accumulator (WIDTH+1-bit sum, carry kept); then shift the accumulator and multiplier right by one.
REQ-014: The bit counter SHALL run 0..WIDTH-1; the edge processing bit WIDTH-1 SHALL load product with the final accumulator and enter DONE.
REQ-015: Latency: capture at edge k -> done=1 and product valid in the cycle after edge k+WIDTH; exactly WIDTH RUN cycles.
REQ-016: DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017: start asserted in RUN or DONE SHALL be ignored; it is not queued, and in-flight operands are unaffected.
REQ-018: Changes on a or b after the accepting edge SHALL NOT affect the result.
REQ-019: product SHALL hold its value from DONE until the next DONE; it SHALL NOT show partial sums.
REQ-020: The result SHALL be exact for all operands, including 0 and 2^WIDTH-1 (max product (2^WIDTH-1)^2, no overflow).
REQ-021: Back-to-back: start held high continuously SHALL be accepted at the edge leaving IDLE, so one operation completes every WIDTH+2 cycles.

Reset
REQ-022: rst_n=0 at an edge SHALL force IDLE, busy=0, done=0, product=0, and counter, accumulator and operand registers to 0, regardless of state.
REQ-023: Reset during RUN or DONE SHALL abort the operation with no done pulse; product reads 0.
REQ-024: With rst_n=0, start SHALL be ignored; the first acceptance is possible at the first edge with rst_n=1.

Structure
REQ-025: A shared package mult_pkg SHALL hold the state enum (IDLE, RUN, DONE), the state encoding width, and the default WIDTH constant.
REQ-026: The adder SHALL be a sub-module ripple_adder (parameter N, inputs x[N], y[N], outputs sum[N], cout), built from the team's full-adder cells and instantiated with N=WIDTH.
REQ-027: Counter width SHALL be $clog2(WIDTH); there SHALL be no combinational path from start, a or b to any output.

Verification
REQ-028: WIDTH=8, a=3, b=5, start pulse -> done high exactly 8 cycles after the accepting edge, product=15, busy high for 9 cycles.
REQ-029: WIDTH=8, a=255, b=255 -> product=65025; a=0, b=200 -> product=0; a=1, b=128 -> product=128.
REQ-030: Start at accepting edge with a=7, b=9; in RUN, change a/b to 0 and pulse start -> product=63, a single done pulse, and no second operation.
REQ-031: rst_n=0 at the 4th RUN cycle of a=10, b=10 -> next cycle IDLE, busy=0, product=0, and no done; a following op 6*7 -> 42.
REQ-032: start held high for 3 operations with operand changes each acceptance -> done pulses spaced 10 cycles apart (WIDTH=8), and each product correct.
REQ-033: Repeat REQ-028 and REQ-029 with WIDTH=4 (15*15=225) and WIDTH=16 (65535*65535=4294836225); latency scales to WIDTH.
